accel_sample_packer: RTL and testbench

ACCEL_SAMPLE_PACKER -- requirements
Module: accel_sample_packer

---
 rtl/accel_sample_packer.sv | 101 ++++++++++
 tb/tb_accel_sample_packer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/accel_sample_packer.sv
// accel_sample_packer: packs six accelerometer register bytes into one {Z,Y,X} sample.
// Optional ACCEL_PACKER_TIMESTAMP_EN adds m_timestamp, the cycle count at byte 0 of the sample.
module accel_sample_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_tdata,
  input  logic        s_tuser,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [47:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [7:0]  drop_count
`ifdef ACCEL_PACKER_TIMESTAMP_EN
  ,
  output logic [31:0] m_timestamp
`endif
);
  typedef enum logic {COLLECT, HOLD} state_t;
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] idle_q, idle_d;
  logic [47:0] data_q, data_d;
  logic [7:0]  drop_q, drop_d;
  logic        started_q;
  logic        acc, drop_inc;
  logic [7:0]  b_in;
  logic        unused_hi;
  assign unused_hi  = ^s_tdata[15:8];
  assign b_in       = s_tdata[7:0];
  assign s_tready   = started_q && state_q == COLLECT;
  assign m_tvalid   = state_q == HOLD;
  assign m_tdata    = data_q;
  assign drop_count = drop_q;
  assign acc        = s_tvalid && s_tready;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    idle_d   = idle_q;
    data_d   = data_q;
    drop_inc = 1'b0;
    if (state_q == HOLD) begin
      idle_d = '0;
      if (m_tready) begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    end else if (acc) begin
      idle_d = '0;
      if (s_tuser) begin
        data_d[7:0] = b_in;
        idx_d       = 3'd1;
        drop_inc    = idx_q != 3'd0;
      end else if (idx_q != 3'd0) begin
        data_d[{idx_q, 3'b000} +: 8] = b_in;
        idx_d   = idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
        state_d = idx_q == 3'd5 ? HOLD : COLLECT;
      end
    end else if (idx_q != 3'd0) begin
      // A beat in the timeout cycle resets the count instead, so the discard lands exactly TIMEOUT_CYCLES idle cycles on.
      drop_inc = idle_q == IDLE_LAST;
      idx_d    = drop_inc ? 3'd0 : idx_q;
      idle_d   = drop_inc ? 16'd0 : idle_q + 16'd1;
    end
    drop_d = (drop_inc && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      idle_q    <= '0;
      data_q    <= '0;
      drop_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
      started_q <= 1'b1;
    end
  end
`ifdef ACCEL_PACKER_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q, ts_d;
  assign ts_d        = (acc && s_tuser) ? ts_cnt_q : ts_q;
  assign m_timestamp = ts_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      ts_q     <= ts_d;
    end
  end
`endif
endmodule

// File: tb/tb_accel_sample_packer.sv
// tb_accel_sample_packer: directed vector table, hand-written corner sequences, and random traffic against a byte-queue model.
module tb_accel_sample_packer;
  localparam int T = 8;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_tdata;
  logic        s_tuser, s_tvalid, s_tready;
  logic [47:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic [7:0]  drop_count;
`ifdef ACCEL_PACKER_TIMESTAMP_EN
  logic [31:0] m_timestamp;
`endif
  accel_sample_packer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .drop_count(drop_count)
`ifdef ACCEL_PACKER_TIMESTAMP_EN
    , .m_timestamp(m_timestamp)
`endif
  );
  always #5 clk = ~clk;
  int pass_cnt = 0;
  int tot_cnt = 0;
  typedef struct {
    logic v, u;
    logic [7:0] d;
    logic mr, er, ev;
    logic [47:0] ed;
    logic [7:0] edrop;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic drive(input logic v, input logic u, input logic [7:0] d, input logic mr);
    s_tvalid = v;
    s_tuser  = u;
    s_tdata  = {8'($urandom), d};
    m_tready = mr;
    @(negedge clk);
  endtask
  function automatic void add(input logic v, u, input logic [7:0] d, input logic mr, er, ev,
                              input logic [47:0] ed, input logic [7:0] edrop);
    vec_t r;
    r.v = v; r.u = u; r.d = d; r.mr = mr; r.er = er; r.ev = ev; r.ed = ed; r.edrop = edrop;
    tbl.push_back(r);
  endfunction
  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, 48'(s_tready), 48'd0);
    chk({nm, "_valid"}, 48'(m_tvalid), 48'd0);
    chk({nm, "_data"}, m_tdata, 48'd0);
    chk({nm, "_drop"}, 48'(drop_count), 48'd0);
  endtask
  bit m_started, m_hold;
  logic [47:0] m_out;
  logic [7:0] q[$];
  int m_idle, m_drop, pv;
  logic [47:0] held;
  logic [31:0] ts1, ts2;
  initial begin
    reset = 1'b1; s_tvalid = 0; s_tuser = 0; s_tdata = 0; m_tready = 0;
    #12 chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_before_edge", 48'(s_tready), 48'd0);
    @(negedge clk);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0);
    add(1, 1, 8'h10, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 1, 1, 0, 0, 0);
    add(1, 0, 8'hFF, 1, 1, 0, 0, 0);
    add(1, 0, 8'hFF, 1, 1, 0, 0, 0);
    add(1, 0, 8'h34, 1, 1, 0, 0, 0);
    add(1, 0, 8'h12, 1, 0, 1, 48'h1234_FFFF_0010, 0);
    add(1, 1, 8'hEE, 1, 1, 0, 0, 0);
    add(1, 1, 8'hAA, 1, 1, 0, 0, 0);
    add(1, 0, 8'hBB, 1, 1, 0, 0, 0);
    add(1, 0, 8'hCC, 1, 1, 0, 0, 0);
    add(1, 1, 8'h01, 1, 1, 0, 0, 1);
    for (int i = 2; i <= 5; i++) add(1, 0, 8'(i), 1, 1, 0, 0, 1);
    add(1, 0, 8'h06, 1, 0, 1, 48'h0605_0403_0201, 1);
    add(0, 0, 8'h00, 1, 1, 0, 0, 1);
    add(1, 1, 8'h55, 1, 1, 0, 0, 1);
    add(1, 0, 8'h66, 1, 1, 0, 0, 1);
    for (int i = 0; i < T - 1; i++) add(0, 0, 8'h00, 1, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 1, 0, 0, 2);
    add(1, 0, 8'h77, 1, 1, 0, 0, 2);
    add(1, 1, 8'h11, 1, 1, 0, 0, 2);
    for (int i = 2; i <= 5; i++) add(1, 0, 8'(i * 16 + i), 1, 1, 0, 0, 2);
    add(1, 0, 8'h66, 1, 0, 1, 48'h6655_4433_2211, 2);
    add(0, 0, 8'h00, 1, 1, 0, 0, 2);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].u, tbl[i].d, tbl[i].mr);
      chk($sformatf("vec%0d_ready", i), 48'(s_tready), 48'(tbl[i].er));
      chk($sformatf("vec%0d_valid", i), 48'(m_tvalid), 48'(tbl[i].ev));
      chk($sformatf("vec%0d_drop", i), 48'(drop_count), 48'(tbl[i].edrop));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), m_tdata, tbl[i].ed);
    end
    drive(1, 1, 8'hA1, 0);
    for (int i = 2; i <= 6; i++) drive(1, 0, 8'(8'hA0 + i), 0);
    held = 48'hA6A5_A4A3_A2A1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_ready", 48'(s_tready), 48'd0);
      chk("bp_valid", 48'(m_tvalid), 48'd1);
      chk("bp_data", m_tdata, held);
      chk("bp_drop", 48'(drop_count), 48'd2);
      drive(i % 2 == 0, 1, 8'h99, 0);
    end
    drive(0, 0, 8'h00, 1);
    chk("bp_release_valid", 48'(m_tvalid), 48'd0);
    chk("bp_release_ready", 48'(s_tready), 48'd1);
    drive(1, 1, 8'hB1, 1);
    drive(1, 0, 8'hB2, 1);
    drive(1, 0, 8'hB3, 1);
    #2 reset = 1'b1;
    #1 chk_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 8'h00, 1);
    for (int i = 4; i <= 6; i++) begin
      drive(1, 0, 8'(8'hB0 + i), 1);
      chk("midreset_novalid", 48'(m_tvalid), 48'd0);
      chk("midreset_drop", 48'(drop_count), 48'd0);
    end
`ifdef ACCEL_PACKER_TIMESTAMP_EN
    drive(1, 1, 8'h01, 1);
    for (int i = 2; i <= 6; i++) drive(1, 0, 8'(i), 1);
    ts1 = m_timestamp;
    chk("ts1_valid", 48'(m_tvalid), 48'd1);
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < 93; i++) drive(0, 0, 8'h00, 1);
    drive(1, 1, 8'h01, 1);
    for (int i = 2; i <= 6; i++) drive(1, 0, 8'(i), 1);
    ts2 = m_timestamp;
    chk("ts2_valid", 48'(m_tvalid), 48'd1);
    chk("ts_delta", 48'(ts2 - ts1), 48'd100);
    drive(0, 0, 8'h00, 1);
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    m_started = 0; m_hold = 0; m_out = 0; q.delete(); m_idle = 0; m_drop = 0; pv = 0;
    for (int c = 0; c < 4000; c++) begin
      logic v, u, mr, r;
      logic [7:0] d;
      if (c % 16 == 0) pv = (c / 16) % 3 == 0 ? 0 : ((c / 16) % 3 == 1 ? 40 : 90);
      v = $urandom_range(99) < pv;
      u = $urandom_range(3) == 0;
      d = 8'($urandom);
      mr = $urandom_range(1) == 1;
      r = m_started && !m_hold;
      drive(v, u, d, mr);
      if (m_hold) begin
        if (mr) m_hold = 0;
      end else if (v && r) begin
        m_idle = 0;
        if (u) begin
          if (q.size() > 0) m_drop++;
          q = {d};
        end else if (q.size() > 0) begin
          q.push_back(d);
          if (q.size() == 6) begin
            m_out = {q[5], q[4], q[3], q[2], q[1], q[0]};
            m_hold = 1;
            q.delete();
          end
        end
      end else if (q.size() > 0) begin
        m_idle++;
        if (m_idle == T) begin
          q.delete();
          m_drop++;
          m_idle = 0;
        end
      end
      if (m_drop > 255) m_drop = 255;
      m_started = 1;
      chk("rnd_ready", 48'(s_tready), 48'(m_started && !m_hold));
      chk("rnd_valid", 48'(m_tvalid), 48'(m_hold));
      chk("rnd_drop", 48'(drop_count), 48'(m_drop));
      if (m_hold) chk("rnd_data", m_tdata, m_out);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
